// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
//   WIDTH-bit shift/rotate register with a single-step path and a burst engine.
//   A single start pulse runs a burst of i_count steps, then o_done pulses.
//
//   Modes (i_mode): 000 hold, 001 rotate left, 010 rotate right,
//                   011 logical left (fill i_ser_in), 100 logical right
//                   (fill i_ser_in), 101 arithmetic right, 110/111 hold.
//
// Ports
//   i_clk, i_rst_n : rising-edge clock, asynchronous active-low reset
//   i_load, din    : parallel load. Highest priority; aborts a burst.
//   i_en           : one step with the live i_mode/i_amt (IDLE only)
//   i_mode, i_amt  : operation select and bit positions moved per step
//   i_ser_in       : fill bit for the logical shifts
//   i_start,i_count: start a burst of i_count steps (IDLE only)
//   dout           : register contents
//   o_busy         : burst in progress
//   o_done         : one-cycle pulse when a burst completes
//   o_zero         : dout == 0 (combinational)
// -----------------------------------------------------------------------------
module universal_shift_register #(
  parameter  int WIDTH = 8,
  parameter  int CNT_W = 8,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] din,
  input  logic             i_en,
  input  logic [2:0]       i_mode,
  input  logic [AW-1:0]    i_amt,
  input  logic             i_ser_in,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_count,
  output logic [WIDTH-1:0] dout,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_zero
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_ROL  = 3'b001,
    M_ROR  = 3'b010,
    M_SLL  = 3'b011,
    M_SRL  = 3'b100,
    M_SRA  = 3'b101
  } mode_t;

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  // One shift/rotate step. The fill masks mark the bit positions vacated by
  // the shift; an amount of 0 gives an empty mask and leaves data unchanged.
  function automatic logic [WIDTH-1:0] step_f(
    input logic [2:0]       mode,
    input logic [AW-1:0]    amt,
    input logic             ser,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] lo_fill;
    logic [WIDTH-1:0] hi_fill;
    lo_fill = ~(ONES << amt);
    hi_fill = ~(ONES >> amt);
    case (mode)
      M_ROL:   step_f = (d << amt) | (d >> (WIDTH - int'(amt)));
      M_ROR:   step_f = (d >> amt) | (d << (WIDTH - int'(amt)));
      M_SLL:   step_f = (d << amt) | (lo_fill & {WIDTH{ser}});
      M_SRL:   step_f = (d >> amt) | (hi_fill & {WIDTH{ser}});
      M_SRA:   step_f = (d >> amt) | (hi_fill & {WIDTH{d[WIDTH-1]}});
      default: step_f = d;  // hold and reserved encodings
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [AW-1:0]    amt_q, amt_d;
  logic             done_d;

  // NOTE: every variable gets its default before the case so that no path
  // leaves one unassigned; otherwise a latch would be inferred.
  always_comb begin
    state_d = state_q;
    dout_d  = dout;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    amt_d   = amt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_load) begin
          dout_d = din;
        end else if (i_start) begin
          mode_d = i_mode;
          amt_d  = i_amt;
          cnt_d  = i_count;
          // A zero-length burst completes at once without touching dout.
          if (i_count != '0) state_d = RUN;
          else               done_d  = 1'b1;
        end else if (i_en) begin
          dout_d = step_f(i_mode, i_amt, i_ser_in, dout);
        end
      end
      RUN: begin
        if (i_load) begin
          // Abort: load wins, burst ends silently (no done pulse).
          dout_d  = din;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          // Mode and amount are frozen at start; the fill bit stays live.
          dout_d = step_f(mode_q, amt_q, i_ser_in, dout);
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values no matter the statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the latched mode/amount are reset along with the datapath, so
      // nothing in the block ever holds an X after reset.
      state_q <= IDLE;
      dout    <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      amt_q   <= '0;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout    <= dout_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      amt_q   <= amt_d;
      o_done  <= done_d;
    end
  end

  assign o_busy = (state_q == RUN);
  assign o_zero = (dout == '0);

endmodule

// File: tb/tb_universal_shift_register.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_register
//   Bench for universal_shift_register. It drives an 8-bit instance and a
//   4-bit instance. Single-step behaviour comes from a vector table. Bursts,
//   aborts and reset are hand-written sequences. Expected dout/busy/done values
//   go into a queue when the stimulus is driven. They are popped and compared
//   at the next falling edge.
// -----------------------------------------------------------------------------
module tb_universal_shift_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       rst_n, load, en, ser, start;
  logic [7:0] din, count, dout;
  logic [2:0] mode, amt;
  logic       busy, done, zero;

  // 4-bit instance (regression of the old rotate-left block)
  logic       load4, en4;
  logic [3:0] din4, dout4;
  logic [2:0] mode4;
  logic [1:0] amt4;
  logic       busy4, done4, zero4;

  universal_shift_register #(.WIDTH(8), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .din(din), .i_en(en),
    .i_mode(mode), .i_amt(amt), .i_ser_in(ser), .i_start(start),
    .i_count(count), .dout(dout), .o_busy(busy), .o_done(done), .o_zero(zero)
  );

  universal_shift_register #(.WIDTH(4), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load4), .din(din4), .i_en(en4),
    .i_mode(mode4), .i_amt(amt4), .i_ser_in(1'b0), .i_start(1'b0),
    .i_count(4'd0), .dout(dout4), .o_busy(busy4), .o_done(done4), .o_zero(zero4)
  );

  typedef struct {
    logic [7:0] din;
    logic [2:0] mode;
    logic [2:0] amt;
    logic       ser;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] dout;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_next(input string name, input logic [7:0] d, input logic b, input logic dn);
    exp_t e;
    e.name = name;
    e.dout = d;
    e.busy = b;
    e.done = dn;
    sb.push_back(e);
  endtask

  // Advance one clock edge and compare the outputs against the oldest entry.
  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: empty at time %0t", $time);
    end else begin
      e = sb.pop_front();
      check($sformatf("%s dout", e.name), 32'(dout), 32'(e.dout));
      check($sformatf("%s busy", e.name), 32'(busy), 32'(e.busy));
      check($sformatf("%s done", e.name), 32'(done), 32'(e.done));
      check($sformatf("%s zero", e.name), 32'(zero), 32'(e.dout == 8'h00));
    end
  endtask

  task automatic idle_inputs();
    load  = 1'b0;
    en    = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t       vecs[14];
  logic [3:0] exp4[4];

  initial begin
    vecs[0]  = '{8'h90, 3'b101, 3'd2, 1'b0, 8'hE4};  // arithmetic right
    vecs[1]  = '{8'h90, 3'b100, 3'd2, 1'b1, 8'hE4};  // logical right, fill 1
    vecs[2]  = '{8'h90, 3'b011, 3'd3, 1'b0, 8'h80};  // logical left, fill 0
    vecs[3]  = '{8'hA5, 3'b001, 3'd0, 1'b0, 8'hA5};  // amt 0 = unchanged
    vecs[4]  = '{8'hA5, 3'b001, 3'd4, 1'b0, 8'h5A};  // rotate left 4
    vecs[5]  = '{8'hA5, 3'b010, 3'd3, 1'b0, 8'hB4};  // rotate right 3
    vecs[6]  = '{8'h81, 3'b011, 3'd1, 1'b1, 8'h03};  // logical left, fill 1
    vecs[7]  = '{8'h81, 3'b100, 3'd1, 1'b0, 8'h40};  // logical right, fill 0
    vecs[8]  = '{8'h81, 3'b101, 3'd1, 1'b0, 8'hC0};  // arithmetic right, sign 1
    vecs[9]  = '{8'h81, 3'b000, 3'd5, 1'b1, 8'h81};  // hold
    vecs[10] = '{8'h81, 3'b110, 3'd1, 1'b1, 8'h81};  // reserved = hold
    vecs[11] = '{8'h81, 3'b111, 3'd7, 1'b1, 8'h81};  // reserved = hold
    vecs[12] = '{8'h7F, 3'b101, 3'd7, 1'b0, 8'h00};  // arithmetic right to zero
    vecs[13] = '{8'h01, 3'b001, 3'd7, 1'b0, 8'h80};  // rotate left by max amt
    exp4     = '{4'b0111, 4'b1110, 4'b1101, 4'b1011};

    rst_n = 1'b0;
    idle_inputs();
    ser = 1'b0; din = '0; mode = '0; amt = '0; count = '0;
    load4 = 1'b0; en4 = 1'b0; din4 = '0; mode4 = '0; amt4 = '0;

    // Reset state
    #2;
    check("reset dout",  32'(dout),  32'h00);
    check("reset busy",  32'(busy),  32'h0);
    check("reset done",  32'(done),  32'h0);
    check("reset zero",  32'(zero),  32'h1);
    check("reset dout4", 32'(dout4), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=4 regression: load 1011, rotate left by 1 four times
    load4 = 1'b1; din4 = 4'b1011;
    @(posedge clk); @(negedge clk);
    check("w4 load", 32'(dout4), 32'hB);
    load4 = 1'b0; en4 = 1'b1; mode4 = 3'b001; amt4 = 2'd1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("w4 rol step%0d", i), 32'(dout4), 32'(exp4[i]));
    end
    en4 = 1'b0;

    // Single-step vector table
    for (int i = 0; i < 14; i++) begin
      idle_inputs();
      load = 1'b1; din = vecs[i].din;
      expect_next($sformatf("vec%0d load", i), vecs[i].din, 1'b0, 1'b0);
      step();
      idle_inputs();
      en = 1'b1; mode = vecs[i].mode; amt = vecs[i].amt; ser = vecs[i].ser;
      expect_next($sformatf("vec%0d step", i), vecs[i].exp, 1'b0, 1'b0);
      step();
    end
    idle_inputs();
    ser = 1'b0;

    // Burst rotate right by 1, count 3; live mode/amt changed mid-burst.
    // Then a back-to-back start on the edge where done falls.
    load = 1'b1; din = 8'hA5;
    expect_next("burst load", 8'hA5, 1'b0, 1'b0); step();
    idle_inputs();
    start = 1'b1; mode = 3'b010; amt = 3'd1; count = 8'd3;
    expect_next("burst E0", 8'hA5, 1'b1, 1'b0); step();
    start = 1'b0; mode = 3'b001; amt = 3'd3;
    expect_next("burst E1", 8'hD2, 1'b1, 1'b0); step();
    expect_next("burst E2", 8'h69, 1'b1, 1'b0); step();
    expect_next("burst E3", 8'hB4, 1'b0, 1'b1); step();
    start = 1'b1; mode = 3'b010; amt = 3'd1; count = 8'd1;
    expect_next("b2b start", 8'hB4, 1'b1, 1'b0); step();
    start = 1'b0;
    expect_next("b2b E1", 8'h5A, 1'b0, 1'b1); step();
    expect_next("b2b after", 8'h5A, 1'b0, 1'b0); step();

    // Abort by load after 2 steps; i_en/i_start ignored while running
    load = 1'b1; din = 8'h81;
    expect_next("abort load", 8'h81, 1'b0, 1'b0); step();
    idle_inputs();
    start = 1'b1; mode = 3'b001; amt = 3'd1; count = 8'd5;
    expect_next("abort E0", 8'h81, 1'b1, 1'b0); step();
    en = 1'b1; mode = 3'b010; amt = 3'd3; count = 8'd1;
    expect_next("abort E1", 8'h03, 1'b1, 1'b0); step();
    expect_next("abort E2", 8'h06, 1'b1, 1'b0); step();
    idle_inputs();
    load = 1'b1; din = 8'h3C;
    expect_next("abort E3", 8'h3C, 1'b0, 1'b0); step();
    idle_inputs();
    expect_next("abort after", 8'h3C, 1'b0, 1'b0); step();

    // Zero-count start, then simultaneous load+start
    start = 1'b1; mode = 3'b001; amt = 3'd1; count = 8'd0;
    expect_next("cnt0 E0", 8'h3C, 1'b0, 1'b1); step();
    start = 1'b0;
    expect_next("cnt0 E1", 8'h3C, 1'b0, 1'b0); step();
    load = 1'b1; start = 1'b1; din = 8'h55; count = 8'd3;
    expect_next("ld+start E0", 8'h55, 1'b0, 1'b0); step();
    idle_inputs();
    expect_next("ld+start E1", 8'h55, 1'b0, 1'b0); step();

    // Async reset mid-burst, then a fresh burst
    load = 1'b1; din = 8'h81;
    expect_next("rst load", 8'h81, 1'b0, 1'b0); step();
    idle_inputs();
    start = 1'b1; mode = 3'b001; amt = 3'd1; count = 8'd5;
    expect_next("rst E0", 8'h81, 1'b1, 1'b0); step();
    start = 1'b0;
    expect_next("rst E1", 8'h03, 1'b1, 1'b0); step();
    #2 rst_n = 1'b0;
    #1;
    check("async rst dout", 32'(dout), 32'h00);
    check("async rst busy", 32'(busy), 32'h0);
    check("async rst done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check("post rst dout", 32'(dout), 32'h00);
    check("post rst busy", 32'(busy), 32'h0);
    load = 1'b1; din = 8'h81;
    expect_next("rerun load", 8'h81, 1'b0, 1'b0); step();
    idle_inputs();
    start = 1'b1; mode = 3'b001; amt = 3'd1; count = 8'd2;
    expect_next("rerun E0", 8'h81, 1'b1, 1'b0); step();
    start = 1'b0;
    expect_next("rerun E1", 8'h03, 1'b1, 1'b0); step();
    expect_next("rerun E2", 8'h06, 1'b0, 1'b1); step();
    expect_next("rerun after", 8'h06, 1'b0, 1'b0); step();

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard leftover: got %0d entries, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
